// File: rtl/lmul_pkg.sv
// Shared types and the round-robin pick helper for the BF16 multiplier front end.
// Pure combinational helpers; no state lives here.
package lmul_pkg;

  localparam int BF16_W  = 16;
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  typedef logic [BF16_W-1:0] bf16_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Search starts one past the last winner and wraps at nreq-1, so the last
  // winner is considered last.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [IDX_W-1:0]   ptr,
                                    input int                 nreq);
    pick_t            r;
    logic [IDX_W-1:0] cand;
    r    = '0;
    cand = ptr;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < nreq) begin
        cand = (int'(cand) == nreq - 1) ? '0 : cand + IDX_W'(1);
        if (!r.found && valid[cand]) begin
          r.found = 1'b1;
          r.idx   = cand;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lmul_tag_fifo.sv
// Tag FIFO recording which requester owns each in-flight product.
// Zero-latency head; push ignored when full, pop ignored when empty.
module lmul_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/lmul_arb.sv
// Round-robin front end sharing one BF16 multiplier among NREQ requesters.
// Zero added latency both ways; issue stalls when DEPTH products are in flight.
module lmul_arb
  import lmul_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int TAGW  = 2,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*BF16_W-1:0]   req_a,
  input  logic [NREQ*BF16_W-1:0]   req_b,
  output logic [NREQ-1:0]          rsp_valid,
  input  logic [NREQ-1:0]          rsp_ready,
  output logic [BF16_W-1:0]        rsp_p,
  output logic                     m_i_valid,
  input  logic                     m_i_ready,
  output logic [BF16_W-1:0]        m_i_a,
  output logic [BF16_W-1:0]        m_i_b,
  input  logic                     m_o_valid,
  output logic                     m_o_ready,
  input  logic [BF16_W-1:0]        m_o_p,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic                     err_orphan
);

  logic [TAGW-1:0] ptr;
  logic [TAGW-1:0] gnt;
  logic [TAGW-1:0] head;
  pick_t           pick;
  logic            full;
  logic            empty;
  logic            accept;
  logic            ret_pop;

  always_comb begin
    pick = rr_pick(MAX_REQ'(req_valid), IDX_W'(ptr), NREQ);
    gnt  = TAGW'(pick.idx);
  end

  // Full blocks issue even when a pop is pending, keeping rsp_ready off the
  // req_ready path.
  assign m_i_valid = pick.found && !full;
  assign m_i_a     = req_a[BF16_W*gnt +: BF16_W];
  assign m_i_b     = req_b[BF16_W*gnt +: BF16_W];
  assign accept    = m_i_valid && m_i_ready;

  always_comb begin
    req_ready = '0;
    if (pick.found) req_ready[gnt] = m_i_ready && !full;
  end

  // With no tag outstanding, stray products are drained and flagged.
  always_comb begin
    rsp_valid = '0;
    m_o_ready = 1'b1;
    if (!empty) begin
      rsp_valid[head] = m_o_valid;
      m_o_ready       = rsp_ready[head];
    end
  end

  assign rsp_p   = m_o_p;
  assign ret_pop = m_o_valid && m_o_ready && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= TAGW'(NREQ - 1);
      err_orphan <= 1'b0;
    end else begin
      if (accept) ptr <= gnt;
      if (m_o_valid && empty) err_orphan <= 1'b1;
    end
  end

  lmul_tag_fifo #(
    .W     (TAGW),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (ret_pop),
    .din   (gnt),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (inflight)
  );

endmodule

// File: tb/tb_lmul_arb.sv
// Scoreboard bench for lmul_arb with a behavioural one-cycle BF16 multiplier.
module tb_lmul_arb;

  localparam int NREQ  = 4;
  localparam int TAGW  = 2;
  localparam int DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*16-1:0]   req_a, req_b;
  logic [15:0]          rsp_p, m_i_a, m_i_b, m_o_p, mq_p;
  logic                 m_i_valid, m_i_ready, m_o_valid, m_o_ready, err_orphan;
  logic                 mq_vld, orphan_force;
  logic [3:0]           inflight;

  assign m_o_valid = mq_vld || orphan_force;
  assign m_o_p     = mq_vld ? mq_p : 16'h7FC0;

  always #5 clk = ~clk;

  lmul_arb #(.NREQ(NREQ), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p),
    .m_i_valid(m_i_valid), .m_i_ready(m_i_ready), .m_i_a(m_i_a), .m_i_b(m_i_b),
    .m_o_valid(m_o_valid), .m_o_ready(m_o_ready), .m_o_p(m_o_p),
    .inflight(inflight), .err_orphan(err_orphan)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_acc = 0;
  int n_ret = 0;

  logic [15:0] sq_a  [NREQ][$];
  logic [15:0] sq_b  [NREQ][$];
  logic [15:0] exp_p [NREQ][$];
  int          exp_grant[$];
  int          exp_order[$];
  logic [31:0] mq[$];

  // Exact for normal operands whose product fits the mantissa.
  function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] prod;
    logic [9:0]  e;
    logic        s;
    s = a[15] ^ b[15];
    if (a[14:7] == 8'd0 || b[14:7] == 8'd0) return {s, 15'd0};
    prod = {1'b1, a[6:0]} * {1'b1, b[6:0]};
    e    = {2'b00, a[14:7]} + {2'b00, b[14:7]} - 10'd127;
    if (prod[15]) return {s, 8'(e + 10'd1), prod[14:8]};
    return {s, e[7:0], prod[13:7]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_req(input int r, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] p);
    sq_a[r].push_back(a);
    sq_b[r].push_back(b);
    exp_p[r].push_back(p);
    exp_grant.push_back(r);
    exp_order.push_back(r);
  endtask

  function automatic bit idle();
    bit r;
    r = (mq.size() == 0);
    for (int i = 0; i < NREQ; i++)
      if (sq_a[i].size() != 0 || exp_p[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!idle() && n < budget) begin tick(); n++; end
    check({name, "_drained"}, 32'(idle()), 32'd1);
  endtask

  task automatic wait_inflight(input string name, input int v, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (int'(inflight) != v && n < budget) begin @(negedge clk); n++; end
    check(name, 32'(inflight), 32'(v));
  endtask

  task automatic clear_sb();
    for (int i = 0; i < NREQ; i++) begin
      sq_a[i].delete(); sq_b[i].delete(); exp_p[i].delete();
    end
    exp_grant.delete();
    exp_order.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_sb();
    @(negedge clk);
    check("rst_inflight", 32'(inflight), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_err_orphan", 32'(err_orphan), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    tick();
  endtask

  // Requester drivers and multiplier model: sample handshakes mid-cycle, apply after the edge.
  initial begin
    logic acc, ret, r;
    logic [NREQ-1:0] hs;
    logic [31:0] ab;
    req_valid = '0; req_a = '0; req_b = '0; mq_vld = 1'b0; mq_p = '0;
    forever begin
      @(negedge clk);
      acc = m_i_valid && m_i_ready;
      ret = m_o_valid && m_o_ready;
      hs  = req_valid & req_ready;
      ab  = {m_i_a, m_i_b};
      r   = rst;
      @(posedge clk);
      #1;
      if (r) mq.delete();
      else begin
        if (ret && mq.size() > 0) void'(mq.pop_front());
        if (acc) mq.push_back(ab);
      end
      for (int i = 0; i < NREQ; i++)
        if (hs[i] && sq_a[i].size() > 0) begin
          void'(sq_a[i].pop_front());
          void'(sq_b[i].pop_front());
        end
      mq_vld = (mq.size() > 0);
      mq_p   = mq_vld ? bf16_mul(mq[0][31:16], mq[0][15:0]) : 16'h0;
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = (sq_a[i].size() > 0);
        req_a[16*i +: 16] = req_valid[i] ? sq_a[i][0] : 16'h0;
        req_b[16*i +: 16] = req_valid[i] ? sq_b[i][0] : 16'h0;
      end
    end
  end

  // Monitor: grants against issue expectations, products against per-requester queues.
  initial begin
    int g;
    forever begin
      @(negedge clk);
      if (!rst && m_i_valid && m_i_ready) begin
        n_acc++;
        check("grant_onehot", 32'($onehot(req_ready)), 32'd1);
        g = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
        check("issue_a", 32'(m_i_a), 32'(req_a[16*g +: 16]));
        check("issue_b", 32'(m_i_b), 32'(req_b[16*g +: 16]));
        if (exp_grant.size() > 0) check("grant_order", 32'(g), 32'(exp_grant.pop_front()));
      end
      if (!rst && rsp_valid != '0) begin
        check("rsp_onehot", 32'($onehot(rsp_valid)), 32'd1);
        for (int i = 0; i < NREQ; i++)
          if (rsp_valid[i] && rsp_ready[i]) begin
            n_ret++;
            if (exp_p[i].size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL unexpected_rsp: requester %0d got %0h, required none", i, rsp_p);
            end else begin
              check($sformatf("rsp_p_%0d", i), 32'(rsp_p), 32'(exp_p[i].pop_front()));
            end
            if (exp_order.size() > 0) check("return_order", 32'(i), 32'(exp_order.pop_front()));
          end
      end
    end
  end

  logic [15:0] ct_a [12] = '{16'h3F80, 16'h3F00, 16'h4080, 16'h4000,
                             16'h4000, 16'hBF80, 16'h4040, 16'h3FC0,
                             16'h4040, 16'h3FC0, 16'h3F80, 16'h4080};
  logic [15:0] ct_b [12] = '{16'h3F80, 16'h4000, 16'h3F00, 16'h4040,
                             16'h4000, 16'h4040, 16'h4040, 16'h4000,
                             16'h4000, 16'h3FC0, 16'hC000, 16'h4080};
  logic [15:0] ct_p [12] = '{16'h3F80, 16'h3F80, 16'h4000, 16'h40C0,
                             16'h4080, 16'hC040, 16'h4110, 16'h4040,
                             16'h40C0, 16'h4010, 16'hC000, 16'h4180};
  logic [15:0] bp_b [10] = '{16'h4000, 16'h4040, 16'h4080, 16'h40C0, 16'h4100,
                             16'h4110, 16'h4120, 16'h4130, 16'h3F00, 16'h3FC0};

  initial begin
    int a0, r0;
    rst = 1'b1; rsp_ready = '1; m_i_ready = 1'b1; orphan_force = 1'b0;

    // Single request from requester 2
    do_reset();
    a0 = n_acc;
    push_req(2, 16'h3F80, 16'h4000, 16'h4000);
    wait_inflight("single_inflight_1", 1, 20);
    wait_inflight("single_inflight_0", 0, 20);
    wait_idle("single", 50);
    check("single_accepts", 32'(n_acc - a0), 32'd1);

    // Full contention: grants must rotate 0,1,2,3 three times
    do_reset();
    a0 = n_acc;
    for (int k = 0; k < 12; k++) push_req(k % 4, ct_a[k], ct_b[k], ct_p[k]);
    wait_idle("contention", 200);
    check("contention_accepts", 32'(n_acc - a0), 32'd12);

    // Backpressure: occupancy saturates and issue is blocked
    do_reset();
    rsp_ready = '0;
    a0 = n_acc; r0 = n_ret;
    for (int k = 0; k < 10; k++) push_req(k % 4, 16'h3F80, bp_b[k], bp_b[k]);
    wait_inflight("bp_saturate", 8, 50);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_inflight_held", 32'(inflight), 32'd8);
      check("bp_req_ready_zero", 32'(req_ready), 32'd0);
      check("bp_m_i_valid_zero", 32'(m_i_valid), 32'd0);
    end
    tick();
    rsp_ready = '1;
    wait_idle("bp", 200);
    check("bp_accepts", 32'(n_acc - a0), 32'd10);
    check("bp_returns", 32'(n_ret - r0), 32'd10);

    // Stalled head: requester 1 owns the head and refuses it
    do_reset();
    rsp_ready = 4'b1101;
    push_req(1, 16'h3F80, 16'h4040, 16'h4040);
    wait_inflight("stall_first", 1, 20);
    push_req(0, 16'h4000, 16'h4000, 16'h4080);
    wait_inflight("stall_second", 2, 20);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stall_m_o_ready", 32'(m_o_ready), 32'd0);
      check("stall_rsp_valid", 32'(rsp_valid), 32'b0010);
    end
    tick();
    rsp_ready = '1;
    wait_idle("stall", 50);

    // Orphan product with an empty tag FIFO
    do_reset();
    orphan_force = 1'b1;
    @(negedge clk);
    check("orphan_rsp_valid", 32'(rsp_valid), 32'd0);
    check("orphan_m_o_ready", 32'(m_o_ready), 32'd1);
    check("orphan_err_before_edge", 32'(err_orphan), 32'd0);
    tick();
    orphan_force = 1'b0;
    @(negedge clk);
    check("orphan_err_set", 32'(err_orphan), 32'd1);
    repeat (5) tick();
    @(negedge clk);
    check("orphan_err_sticky", 32'(err_orphan), 32'd1);

    // Mid-flight reset: three tags discarded, priority returns to requester 0
    do_reset();
    rsp_ready = '0;
    for (int k = 0; k < 3; k++) push_req(k, 16'h3F80, bp_b[k], bp_b[k]);
    wait_inflight("mid_inflight_3", 3, 20);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_sb();
    @(negedge clk);
    check("mid_inflight_0", 32'(inflight), 32'd0);
    check("mid_err_orphan", 32'(err_orphan), 32'd0);
    tick();
    rsp_ready = '1;
    a0 = n_acc;
    for (int k = 0; k < 4; k++) push_req(k, ct_a[k], ct_b[k], ct_p[k]);
    wait_idle("mid", 50);
    check("mid_accepts", 32'(n_acc - a0), 32'd4);
    @(negedge clk);
    check("mid_err_orphan_after", 32'(err_orphan), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
